// File: rtl/ecpu_bus_pkg.sv
// Shared types and constants for the unified-memory Wishbone arbiter.
package ecpu_bus_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D} arb_state_e;
   typedef enum logic {OWN_IMEM, OWN_DMEM} owner_e;

   localparam int unsigned WB_XLEN  = 32;
   localparam int unsigned WB_SEL_W = WB_XLEN / 8;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Classic Wishbone port bundle; "master" drives requests, "slave" returns responses.
interface wb_mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned XLEN       = 32
) ();
   logic                  cyc;
   logic                  stb;
   logic                  we;
   logic [ADDR_WIDTH-1:0] adr;
   logic [XLEN-1:0]       dat_w;
   logic [XLEN/8-1:0]     sel;
   logic                  ack;
   logic                  err;
   logic [XLEN-1:0]       dat_r;

   modport master (output cyc, stb, we, adr, dat_w, sel, input ack, err, dat_r);
   modport slave  (input cyc, stb, we, adr, dat_w, sel, output ack, err, dat_r);
endinterface

// File: rtl/wb_arb_picker.sv
// Combinational grant decision for the IDLE cycle: single requester wins, ties go
// to the master opposite the last owner (round robin) or to dmem (fixed).
module wb_arb_picker
   import ecpu_bus_pkg::*;
(
   input  logic [1:0] req_i,
   input  owner_e     last_owner_i,
   input  logic       rr_en_i,
   output owner_e     grant_o,
   output logic       valid_o
);

   always_comb begin
      valid_o = |req_i;
      case (req_i)
         2'b01:   grant_o = OWN_IMEM;
         2'b10:   grant_o = OWN_DMEM;
         2'b11: begin
            if (rr_en_i) begin
               grant_o = (last_owner_i == OWN_IMEM) ? OWN_DMEM : OWN_IMEM;
            end else begin
               grant_o = OWN_DMEM;
            end
         end
         default: grant_o = OWN_IMEM;
      endcase
   end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Shares one classic Wishbone slave between the fetch (imem) and load/store (dmem)
// masters, with a registered grant FSM, per-transfer timeout and contention counter.
module wb_mem_arbiter
   import ecpu_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned XLEN        = WB_XLEN,
   parameter int unsigned ROUND_ROBIN = 1,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   wb_mem_arbiter_if.slave        imem,
   wb_mem_arbiter_if.slave        dmem,
   wb_mem_arbiter_if.master       mem,
   output logic [1:0]             owner_o,
   output logic [31:0]            contention_cnt_o
);

   localparam int unsigned    TW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TW-1:0]  TO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
   localparam logic           RR_EN   = (ROUND_ROBIN != 0);

   arb_state_e     r_state;
   owner_e         r_last_owner;
   logic [TW-1:0]  r_timer;
   logic [1:0]     r_owner;
   logic [31:0]    r_cnt;

   logic [1:0]     w_req;
   owner_e         w_grant;
   logic           w_valid;
   logic           w_busy;
   logic           w_own_cyc;
   logic           w_resp;
   logic           w_timeout;

   assign w_req     = {dmem.cyc & dmem.stb, imem.cyc & imem.stb};
   assign w_busy    = (r_state == ARB_BUSY_I) || (r_state == ARB_BUSY_D);
   assign w_own_cyc = (r_state == ARB_BUSY_I) ? imem.cyc :
                      (r_state == ARB_BUSY_D) ? dmem.cyc : 1'b0;
   assign w_resp    = mem.ack | mem.err;
   // A slave response in the last allowed cycle beats the forced error.
   assign w_timeout = (TIMEOUT_CYC != 0) && w_busy && w_own_cyc && !w_resp && (r_timer == TO_LAST);

   assign owner_o          = r_owner;
   assign contention_cnt_o = r_cnt;

   wb_arb_picker u_picker (
      .req_i        (w_req),
      .last_owner_i (r_last_owner),
      .rr_en_i      (RR_EN),
      .grant_o      (w_grant),
      .valid_o      (w_valid)
   );

   always_comb begin
      mem.cyc    = 1'b0;
      mem.stb    = 1'b0;
      mem.we     = 1'b0;
      mem.adr    = '0;
      mem.dat_w  = '0;
      mem.sel    = '0;
      imem.ack   = 1'b0;
      imem.err   = 1'b0;
      imem.dat_r = '0;
      dmem.ack   = 1'b0;
      dmem.err   = 1'b0;
      dmem.dat_r = '0;
      case (r_state)
         ARB_BUSY_I: begin
            if (!w_timeout) begin
               mem.cyc   = imem.cyc;
               mem.stb   = imem.stb;
               mem.we    = imem.we;
               mem.adr   = imem.adr;
               mem.dat_w = imem.dat_w;
               mem.sel   = imem.sel;
            end else begin
               mem.cyc   = 1'b0;
            end
            // Responses stop the moment the owner abandons the cycle.
            if (imem.cyc) begin
               imem.ack   = mem.ack;
               imem.err   = mem.err | w_timeout;
               imem.dat_r = mem.dat_r;
            end else begin
               imem.ack   = 1'b0;
            end
         end
         ARB_BUSY_D: begin
            if (!w_timeout) begin
               mem.cyc   = dmem.cyc;
               mem.stb   = dmem.stb;
               mem.we    = dmem.we;
               mem.adr   = dmem.adr;
               mem.dat_w = dmem.dat_w;
               mem.sel   = dmem.sel;
            end else begin
               mem.cyc   = 1'b0;
            end
            if (dmem.cyc) begin
               dmem.ack   = mem.ack;
               dmem.err   = mem.err | w_timeout;
               dmem.dat_r = mem.dat_r;
            end else begin
               dmem.ack   = 1'b0;
            end
         end
         default: begin
            mem.cyc = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= ARB_IDLE;
         r_last_owner <= OWN_IMEM;
         r_timer      <= '0;
         r_owner      <= 2'b00;
         r_cnt        <= 32'd0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               r_timer <= '0;
               if (w_req == 2'b11 && r_cnt != 32'hFFFF_FFFF) begin
                  r_cnt <= r_cnt + 32'd1;
               end
               if (w_valid) begin
                  r_state <= (w_grant == OWN_DMEM) ? ARB_BUSY_D : ARB_BUSY_I;
                  r_owner <= (w_grant == OWN_DMEM) ? 2'b10 : 2'b01;
               end else begin
                  r_owner <= 2'b00;
               end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
               if (!w_own_cyc || w_resp || w_timeout) begin
                  r_state <= ARB_IDLE;
                  r_owner <= 2'b00;
                  r_timer <= '0;
                  if (w_own_cyc && w_resp) begin
                     r_last_owner <= (r_state == ARB_BUSY_D) ? OWN_DMEM : OWN_IMEM;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: begin
               r_state <= ARB_IDLE;
               r_owner <= 2'b00;
            end
         endcase
      end
   end

endmodule
